// File: rtl/core_mem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, operation codes and
// the grant-index width helper.
package core_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } mem_op_e;

  // Width of a core index; a single core still needs a one-bit index.
  function automatic int grant_width(input int n_cores);
    return (n_cores > 1) ? $clog2(n_cores) : 1;
  endfunction

  localparam int N_CORES_DEF = 4;
  localparam int GRANT_W     = grant_width(N_CORES_DEF);

endpackage

// File: rtl/core_mem_arbiter_if.sv
// Core-side bundle of the data-memory arbiter: per-core requests in,
// one-hot acknowledge and broadcast read data out.
interface core_mem_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8
);

  logic [N_CORES-1:0]        req_rd;
  logic [N_CORES-1:0]        req_wr;
  logic [N_CORES*ADDR_W-1:0] req_addr;
  logic [N_CORES*DATA_W-1:0] req_wdata;
  logic [N_CORES-1:0]        dacq;
  logic [DATA_W-1:0]         core_rdata;

  // Cores side.
  modport master (
    output req_rd, req_wr, req_addr, req_wdata,
    input  dacq, core_rdata
  );

  // Arbiter side.
  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata,
    output dacq, core_rdata
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first eligible requester
// scanning upward from the one after rr_last, wrapping at N_CORES.
module rr_picker
  import core_mem_pkg::*;
#(
  parameter  int N_CORES = 4,
  localparam int GW      = grant_width(N_CORES)
) (
  input  logic [N_CORES-1:0] req,
  input  logic [N_CORES-1:0] mask,
  input  logic [GW-1:0]      rr_last,
  output logic [GW-1:0]      winner,
  output logic               valid
);

  logic [N_CORES-1:0] eligible;
  logic [GW-1:0]      idx;

  assign eligible = req & ~mask;

  // Scan rr_last+1 .. rr_last+N_CORES and keep the first hit.
  always_comb begin
    // NOTE: every output gets a default before the loop; a path that leaves
    // one unassigned would infer a latch.
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_CORES; k++) begin
      idx = GW'((int'(rr_last) + k) % N_CORES);
      if (!valid && eligible[idx]) begin
        valid  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shared data-memory arbiter: serialises per-core read/write requests onto
// one synchronous RAM with round-robin priority and a one-cycle dacq.
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter  int N_CORES = 4,
  parameter  int DATA_W  = 8,
  parameter  int ADDR_W  = 8,
  parameter  int MEM_LAT = 1,
  localparam int GW      = grant_width(N_CORES)
) (
  input  logic               CLK,
  input  logic               RST,
  core_mem_arbiter_if.slave  bus,
  output logic               busy,
  output logic [GW-1:0]      grant_id,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_we,
  input  logic [DATA_W-1:0]  mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  arb_state_e         state_q, state_d;
  mem_op_e            op_q;
  logic [GW-1:0]      grant_q;
  logic [GW-1:0]      rr_last_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [N_CORES-1:0] holdoff_q;

  logic [N_CORES-1:0] req_any;
  logic [N_CORES-1:0] grant_onehot;
  logic [GW-1:0]      pick_id;
  logic               pick_valid;

  assign req_any      = bus.req_rd | bus.req_wr;
  assign grant_onehot = {{(N_CORES-1){1'b0}}, 1'b1} << grant_q;

  rr_picker #(.N_CORES(N_CORES)) u_picker (
    .req     (req_any),
    .mask    (holdoff_q),
    .rr_last (rr_last_q),
    .winner  (pick_id),
    .valid   (pick_valid)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before this edge.
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and the state-decoded outputs.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    mem_we   = 1'b0;
    bus.dacq = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) state_d = ACCESS;
      end
      ACCESS: begin
        busy   = 1'b1;
        mem_we = (op_q == OP_WR);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        bus.dacq = grant_onehot;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, access timer, read capture and round-robin bookkeeping.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: the latched request fields are reset as well, so mem_addr and
    // mem_wdata read zero straight out of reset or after an aborted access.
    if (RST) begin
      op_q      <= OP_RD;
      grant_q   <= '0;
      rr_last_q <= GW'(N_CORES - 1);
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      holdoff_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // The holdoff mask only shields the first IDLE cycle after DONE.
          holdoff_q <= '0;
          if (pick_valid) begin
            grant_q <= pick_id;
            op_q    <= bus.req_wr[pick_id] ? OP_WR : OP_RD;
            addr_q  <= bus.req_addr[pick_id*ADDR_W +: ADDR_W];
            wdata_q <= bus.req_wdata[pick_id*DATA_W +: DATA_W];
            cnt_q   <= bus.req_wr[pick_id] ? '0 : CNT_W'(MEM_LAT);
          end
        end
        ACCESS: begin
          if (cnt_q != '0)        cnt_q   <= cnt_q - CNT_W'(1);
          else if (op_q == OP_RD) rdata_q <= mem_rdata;
        end
        DONE: begin
          rr_last_q <= grant_q;
          holdoff_q <= grant_onehot;
        end
        default: ;
      endcase
    end
  end

  assign grant_id       = grant_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign bus.core_rdata = rdata_q;

endmodule
